// File: rtl/frv_pipeline_realign_pkg.sv
// Shared constants and types for the fetch realignment block.
// Size encodings, the queue entry layout and the compressed-encoding test.
package frv_pipeline_realign_pkg;

    localparam logic [1:0] SIZE_NONE = 2'b00;
    localparam logic [1:0] SIZE_16   = 2'b01;
    localparam logic [1:0] SIZE_32   = 2'b10;

    typedef struct packed {
        logic [15:0] hw;
        logic        err;
    } hw_entry_t;

    function automatic logic is_compressed(input logic [15:0] hw, input logic rvc_en);
        return rvc_en && (hw[1:0] != 2'b11);
    endfunction

endpackage

// File: rtl/frv_halfword_fifo.sv
// Circular halfword queue: pushes 0-2 halfwords and pops 0-2 halfwords per cycle, with flush.
// Latency: a pushed halfword is visible at head0/head1 the cycle after the push.
// Backpressure: none internally; the caller must only push when at least push_cnt entries are free.
module frv_halfword_fifo
    import frv_pipeline_realign_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          g_clk,
    input  logic          g_reset,
    input  logic          flush,
    input  logic [1:0]    push_cnt,
    input  hw_entry_t     push_lo,
    input  hw_entry_t     push_hi,
    input  logic [1:0]    pop_cnt,
    output hw_entry_t     head0,
    output hw_entry_t     head1,
    output logic [CW-1:0] count
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   DEPTH_P = (PW+1)'(DEPTH);

    hw_entry_t         mem [DEPTH];
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr1;
    logic [PW-1:0]     wr_ptr1;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] p, input logic [1:0] n);
        logic [PW:0] s;
        s = {1'b0, p} + (PW+1)'(n);
        if (s >= DEPTH_P) s = s - DEPTH_P;
        return s[PW-1:0];
    endfunction

    assign rd_ptr1 = wrap_add(rd_ptr, 2'd1);
    assign wr_ptr1 = wrap_add(wr_ptr, 2'd1);
    assign head0   = mem[rd_ptr];
    assign head1   = mem[rd_ptr1];

    always_ff @(posedge g_clk) begin
        if (g_reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            rd_ptr <= wrap_add(rd_ptr, pop_cnt);
            wr_ptr <= wrap_add(wr_ptr, push_cnt);
            count  <= count + CW'(push_cnt) - CW'(pop_cnt);
        end
    end

    always_ff @(posedge g_clk) begin
        if (push_cnt != 2'd0) mem[wr_ptr]  <= push_lo;
        if (push_cnt == 2'd2) mem[wr_ptr1] <= push_hi;
    end

endmodule

// File: rtl/frv_pipeline_realign.sv
// Realigns word fetches into 16/32-bit instructions with PC, error and illegal flags.
// Latency: a halfword accepted in cycle N can be presented at d_* in cycle N+1.
// Backpressure: f_ready needs two free entries by registered count; d_* hold while !d_ready.
module frv_pipeline_realign
    import frv_pipeline_realign_pkg::*;
#(
    parameter logic [31:0] FRV_PC_RESET_VALUE = 32'h8000_0000,
    parameter int          BUF_DEPTH          = 8,
    parameter bit          RVC_EN             = 1'b1
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        f_valid,
    output logic        f_ready,
    input  logic [31:0] f_data,
    input  logic        f_error,
    input  logic        cf_req,
    input  logic [31:0] cf_target,
    output logic        d_valid,
    input  logic        d_ready,
    output logic [31:0] d_data,
    output logic [31:0] d_pc,
    output logic [1:0]  d_size,
    output logic        d_error,
    output logic        d_ill
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    logic [CW-1:0] count;
    hw_entry_t     head0;
    hw_entry_t     head1;
    hw_entry_t     push_lo;
    hw_entry_t     push_hi;
    logic [1:0]    push_cnt;
    logic [1:0]    pop_cnt;
    logic [31:0]   pc;
    logic          drop;
    logic          head_single;
    logic          accept;
    logic          consume;

    // An errored head halfword is reported on its own rather than paired.
    assign head_single = is_compressed(head0.hw, RVC_EN) || head0.err;

    assign f_ready = !g_reset && !cf_req && (count <= CW'(BUF_DEPTH - 2));
    assign d_valid = !g_reset && !cf_req &&
                     (((count >= CW'(1)) && head_single) || (count >= CW'(2)));
    assign d_size  = !d_valid ? SIZE_NONE : (head_single ? SIZE_16 : SIZE_32);
    assign d_data  = head_single ? {16'h0000, head0.hw} : {head1.hw, head0.hw};
    assign d_pc    = pc;
    assign d_error = d_valid && (head0.err || (!head_single && head1.err));
    assign d_ill   = d_valid && !RVC_EN && !head0.err && (head0.hw[1:0] != 2'b11);

    assign accept   = f_valid && f_ready;
    assign consume  = d_valid && d_ready;
    assign push_cnt = !accept ? 2'd0 : (drop ? 2'd1 : 2'd2);
    assign push_lo  = drop ? hw_entry_t'{f_data[31:16], f_error} : hw_entry_t'{f_data[15:0], f_error};
    assign push_hi  = hw_entry_t'{f_data[31:16], f_error};
    assign pop_cnt  = !consume ? 2'd0 : (head_single ? 2'd1 : 2'd2);

    frv_halfword_fifo #(
        .DEPTH    (BUF_DEPTH)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_reset  (g_reset),
        .flush    (cf_req),
        .push_cnt (push_cnt),
        .push_lo  (push_lo),
        .push_hi  (push_hi),
        .pop_cnt  (pop_cnt),
        .head0    (head0),
        .head1    (head1),
        .count    (count)
    );

    // A target in the upper halfword means the first fetched low halfword is stale.
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            pc   <= FRV_PC_RESET_VALUE;
            drop <= FRV_PC_RESET_VALUE[1];
        end else if (cf_req) begin
            pc   <= cf_target & ~32'd1;
            drop <= cf_target[1];
        end else begin
            if (consume) pc <= pc + (head_single ? 32'd2 : 32'd4);
            if (accept) drop <= 1'b0;
        end
    end

endmodule
